bank_ring_scheduler: RTL and testbench

- Parametrised successor to the fixed two-buffer (first/second) arrangement between external-memory fill and PE-array drain.
- Manages NUM_BANKS memory_buffer banks as a ring: the DMA/fill side is granted FREE banks in ring order; the PE-array side drains FULL banks in the same order.
- Generalises ping-pong to N-deep multi-buffering, overlapping extmem transfer with compute.
- Sits inside the controller between the extmem DMA sequencer and the PE-array sequencer. Drives bank-select only; buffer datapaths are untouched.

---
 rtl/bank_ring_if.sv | 32 +++
 rtl/bank_ring_scheduler.sv | 166 ++++++++++++++++
 tb/tb_bank_ring_scheduler.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bank_ring_if.sv
// Handshake bundle between the bank ring scheduler and its clients.
// master: DMA fill sequencer and PE-array drain sequencer (plus flush source).
// slave : the scheduler itself.
interface bank_ring_if #(parameter int NUM_BANKS = 2);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int CNT_W  = $clog2(NUM_BANKS + 1);

    logic              flush;
    logic              fill_req;
    logic              fill_gnt;
    logic [BANK_W-1:0] fill_bank;
    logic              fill_done;
    logic              drain_valid;
    logic              drain_ready;
    logic [BANK_W-1:0] drain_bank;
    logic              drain_done;
    logic [CNT_W-1:0]  full_count;
    logic [CNT_W-1:0]  free_count;
    logic              proto_err;

    modport master (
        output flush, fill_req, fill_done, drain_ready, drain_done,
        input  fill_gnt, fill_bank, drain_valid, drain_bank,
               full_count, free_count, proto_err
    );

    modport slave (
        input  flush, fill_req, fill_done, drain_ready, drain_done,
        output fill_gnt, fill_bank, drain_valid, drain_bank,
               full_count, free_count, proto_err
    );
endinterface

// File: rtl/bank_ring_scheduler.sv
// Ring scheduler for NUM_BANKS buffer banks: fill side is granted FREE banks
// in ring order, drain side is offered FULL banks in the same order.
// Optional stall counters are enabled with BANK_RING_STATS_EN.
module bank_ring_scheduler #(
    parameter int NUM_BANKS = 2
) (
    input  logic         clk,
    input  logic         rst,
    bank_ring_if.slave   bus
`ifdef BANK_RING_STATS_EN
    ,
    output logic [31:0]  fill_stall_cnt,
    output logic [31:0]  drain_stall_cnt
`endif
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int CNT_W  = $clog2(NUM_BANKS + 1);

    typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_DRAINING} bank_st_e;

    bank_st_e          bank_q [NUM_BANKS];
    bank_st_e          bank_d [NUM_BANKS];
    logic [BANK_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [BANK_W-1:0] fill_bank_q, fill_bank_d;
    logic              fill_busy_q, fill_busy_d, drain_busy_q, drain_busy_d;
    logic              fill_gnt_q, fill_gnt_d, drain_valid_q, drain_valid_d;
    logic              proto_err_q, proto_err_d;
    logic [CNT_W-1:0]  full_cnt_q, full_cnt_d, free_cnt_q, free_cnt_d;
    logic              grant, fill_ok, accept, drain_ok;

    // Pointers are not power-of-two sized, so wrap explicitly.
    function automatic logic [BANK_W-1:0] ring_inc(input logic [BANK_W-1:0] p);
        return (p == BANK_W'(NUM_BANKS - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next-state for bank states, pointers, handshakes and counts.
    always_comb begin
        bank_d        = bank_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fill_bank_d   = fill_bank_q;
        fill_busy_d   = fill_busy_q;
        drain_busy_d  = drain_busy_q;
        fill_gnt_d    = 1'b0;
        proto_err_d   = proto_err_q;

        // grant and fill_ok are mutually exclusive via fill_busy; likewise
        // accept (needs drain_valid, hence !drain_busy) and drain_ok.
        grant    = bus.fill_req && !fill_busy_q && (bank_q[wr_ptr_q] == B_FREE);
        fill_ok  = bus.fill_done && fill_busy_q;
        accept   = drain_valid_q && bus.drain_ready;
        drain_ok = bus.drain_done && drain_busy_q;

        if (grant) begin
            bank_d[wr_ptr_q] = B_FILLING;
            fill_busy_d      = 1'b1;
            fill_gnt_d       = 1'b1;
            fill_bank_d      = wr_ptr_q;
        end
        if (fill_ok) begin
            bank_d[fill_bank_q] = B_FULL;
            wr_ptr_d            = ring_inc(wr_ptr_q);
            fill_busy_d         = 1'b0;
        end
        if (accept) begin
            bank_d[rd_ptr_q] = B_DRAINING;
            drain_busy_d     = 1'b1;
        end
        if (drain_ok) begin
            bank_d[rd_ptr_q] = B_FREE;
            rd_ptr_d         = ring_inc(rd_ptr_q);
            drain_busy_d     = 1'b0;
        end
        if ((bus.fill_done && !fill_busy_q) || (bus.drain_done && !drain_busy_q))
            proto_err_d = 1'b1;

        // Flush wins over everything except the sticky error flag.
        if (bus.flush) begin
            for (int i = 0; i < NUM_BANKS; i++) bank_d[i] = B_FREE;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            fill_bank_d  = '0;
            fill_busy_d  = 1'b0;
            drain_busy_d = 1'b0;
            fill_gnt_d   = 1'b0;
        end

        // Outputs are derived from the next state so they line up with it.
        drain_valid_d = !drain_busy_d && (bank_d[rd_ptr_d] == B_FULL);
        full_cnt_d    = '0;
        free_cnt_d    = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (bank_d[i] == B_FULL) full_cnt_d = full_cnt_d + 1'b1;
            if (bank_d[i] == B_FREE) free_cnt_d = free_cnt_d + 1'b1;
        end
    end

    // State registers with async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_BANKS; i++) bank_q[i] <= B_FREE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fill_bank_q   <= '0;
            fill_busy_q   <= 1'b0;
            drain_busy_q  <= 1'b0;
            fill_gnt_q    <= 1'b0;
            drain_valid_q <= 1'b0;
            proto_err_q   <= 1'b0;
            full_cnt_q    <= '0;
            free_cnt_q    <= CNT_W'(NUM_BANKS);
        end else begin
            bank_q        <= bank_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fill_bank_q   <= fill_bank_d;
            fill_busy_q   <= fill_busy_d;
            drain_busy_q  <= drain_busy_d;
            fill_gnt_q    <= fill_gnt_d;
            drain_valid_q <= drain_valid_d;
            proto_err_q   <= proto_err_d;
            full_cnt_q    <= full_cnt_d;
            free_cnt_q    <= free_cnt_d;
        end
    end

    assign bus.fill_gnt    = fill_gnt_q;
    assign bus.fill_bank   = fill_bank_q;
    assign bus.drain_valid = drain_valid_q;
    assign bus.drain_bank  = rd_ptr_q;
    assign bus.full_count  = full_cnt_q;
    assign bus.free_count  = free_cnt_q;
    assign bus.proto_err   = proto_err_q;

`ifdef BANK_RING_STATS_EN
    logic [31:0] fill_stall_q, fill_stall_d, drain_stall_q, drain_stall_d;

    // Saturating stall counters, cleared by flush.
    always_comb begin
        fill_stall_d  = fill_stall_q;
        drain_stall_d = drain_stall_q;
        if (bus.fill_req && !fill_busy_q && (bank_q[wr_ptr_q] != B_FREE) && (fill_stall_q != '1))
            fill_stall_d = fill_stall_q + 1'b1;
        if (bus.drain_ready && !drain_valid_q && !drain_busy_q && (drain_stall_q != '1))
            drain_stall_d = drain_stall_q + 1'b1;
        if (bus.flush) begin
            fill_stall_d  = '0;
            drain_stall_d = '0;
        end
    end

    // Stall counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_stall_q  <= '0;
            drain_stall_q <= '0;
        end else begin
            fill_stall_q  <= fill_stall_d;
            drain_stall_q <= drain_stall_d;
        end
    end

    assign fill_stall_cnt  = fill_stall_q;
    assign drain_stall_cnt = drain_stall_q;
`endif
endmodule

// File: tb/tb_bank_ring_scheduler.sv
// Bench for bank_ring_scheduler: a 3-bank and a 2-bank instance checked
// every cycle against a transaction-count model, plus literal expectations.
module tb_bank_ring_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bank_ring_if #(.NUM_BANKS(3)) b3();
    bank_ring_if #(.NUM_BANKS(2)) b2();

`ifdef BANK_RING_STATS_EN
    logic [31:0] fsc3, dsc3, fsc2, dsc2;
    bank_ring_scheduler #(.NUM_BANKS(3)) dut3 (.clk(clk), .rst(rst), .bus(b3),
        .fill_stall_cnt(fsc3), .drain_stall_cnt(dsc3));
    bank_ring_scheduler #(.NUM_BANKS(2)) dut2 (.clk(clk), .rst(rst), .bus(b2),
        .fill_stall_cnt(fsc2), .drain_stall_cnt(dsc2));
`else
    bank_ring_scheduler #(.NUM_BANKS(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));
    bank_ring_scheduler #(.NUM_BANKS(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
`endif

    // Stimulus per instance: index 0 = 3 banks, index 1 = 2 banks.
    logic freq[2], fdone[2], dready[2], ddone[2], fl[2];
    assign b3.fill_req = freq[0];  assign b2.fill_req = freq[1];
    assign b3.fill_done = fdone[0]; assign b2.fill_done = fdone[1];
    assign b3.drain_ready = dready[0]; assign b2.drain_ready = dready[1];
    assign b3.drain_done = ddone[0]; assign b2.drain_done = ddone[1];
    assign b3.flush = fl[0]; assign b2.flush = fl[1];

    logic o_gnt[2], o_dv[2], o_pe[2];
    int   o_fb[2], o_db[2], o_full[2], o_free[2];
    assign o_gnt[0] = b3.fill_gnt;      assign o_gnt[1] = b2.fill_gnt;
    assign o_dv[0]  = b3.drain_valid;   assign o_dv[1]  = b2.drain_valid;
    assign o_pe[0]  = b3.proto_err;     assign o_pe[1]  = b2.proto_err;
    assign o_fb[0]  = int'(b3.fill_bank);  assign o_fb[1]  = int'(b2.fill_bank);
    assign o_db[0]  = int'(b3.drain_bank); assign o_db[1]  = int'(b2.drain_bank);
    assign o_full[0] = int'(b3.full_count); assign o_full[1] = int'(b2.full_count);
    assign o_free[0] = int'(b3.free_count); assign o_free[1] = int'(b2.free_count);

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the ring is described only by running transaction totals.
    // granted - drain_completed = banks not FREE; fill_completed - drain_accepted = FULL.
    int NB[2] = '{3, 2};
    int g_cnt[2], fc_cnt[2], da_cnt[2], dc_cnt[2];
    bit m_fb[2], m_db[2], m_gnt[2], m_pe[2];

    function automatic bit m_dv(input int k);
        return !m_db[k] && ((fc_cnt[k] - da_cnt[k]) > 0);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                g_cnt[k] = 0; fc_cnt[k] = 0; da_cnt[k] = 0; dc_cnt[k] = 0;
                m_fb[k] = 0; m_db[k] = 0; m_gnt[k] = 0; m_pe[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit gr, acc;
                if (fl[k]) begin
                    g_cnt[k] = 0; fc_cnt[k] = 0; da_cnt[k] = 0; dc_cnt[k] = 0;
                    m_fb[k] = 0; m_db[k] = 0; m_gnt[k] = 0;
                end else begin
                    gr  = freq[k] && !m_fb[k] && ((g_cnt[k] - dc_cnt[k]) < NB[k]);
                    acc = m_dv(k) && dready[k];
                    if (fdone[k]) begin
                        if (m_fb[k]) begin fc_cnt[k]++; m_fb[k] = 0; end
                        else m_pe[k] = 1;
                    end
                    if (ddone[k]) begin
                        if (m_db[k]) begin dc_cnt[k]++; m_db[k] = 0; end
                        else m_pe[k] = 1;
                    end
                    if (acc) begin da_cnt[k]++; m_db[k] = 1; end
                    m_gnt[k] = gr;
                    if (gr) begin g_cnt[k]++; m_fb[k] = 1; end
                end
            end
        end
    end

    // Per-cycle comparison away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                string p;
                p = $sformatf("n%0d.", NB[k]);
                check({p, "fill_gnt"},    int'(o_gnt[k]), int'(m_gnt[k]));
                check({p, "fill_bank"},   o_fb[k], (g_cnt[k] == 0) ? 0 : (g_cnt[k] - 1) % NB[k]);
                check({p, "drain_valid"}, int'(o_dv[k]), int'(m_dv(k)));
                check({p, "drain_bank"},  o_db[k], dc_cnt[k] % NB[k]);
                check({p, "full_count"},  o_full[k], fc_cnt[k] - da_cnt[k]);
                check({p, "free_count"},  o_free[k], NB[k] - (g_cnt[k] - dc_cnt[k]));
                check({p, "proto_err"},   int'(o_pe[k]), int'(m_pe[k]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            freq[k] = 0; fdone[k] = 0; dready[k] = 0; ddone[k] = 0; fl[k] = 0;
        end
        #1 rst = 1'b0;
        #10;
        check("rst.free3", o_free[0], 3);
        check("rst.free2", o_free[1], 2);
        check("rst.full3", o_full[0], 0);
        check("rst.dv3",   int'(o_dv[0]), 0);
        check("rst.gnt3",  int'(o_gnt[0]), 0);
        @(negedge clk) rst = 1'b1;
        tick(); tick();
        check("idle.free3", o_free[0], 3);
        check("idle.dv3",   int'(o_dv[0]), 0);
        check("idle.pe3",   int'(o_pe[0]), 0);

        // Three fills with PE side idle: banks 0,1,2 in order.
        for (int i = 0; i < 3; i++) begin
            freq[0] = 1; tick();
            check("fill.gnt", int'(o_gnt[0]), 1);
            check("fill.bank", o_fb[0], i);
            freq[0] = 0; fdone[0] = 1; tick();
            fdone[0] = 0;
            check("fill.full", o_full[0], i + 1);
            check("fill.gnt_pulse", int'(o_gnt[0]), 0);
        end
        check("ring_full.free", o_free[0], 0);
        check("ring_full.dv", int'(o_dv[0]), 1);
        freq[0] = 1; tick(); tick(); tick();
        check("ring_full.nogrant", int'(o_gnt[0]), 0);
`ifdef BANK_RING_STATS_EN
        check("ring_full.stall", int'(fsc3 >= 32'd2), 1);
`endif
        freq[0] = 0;

        // Drain all three in ring order.
        for (int i = 0; i < 3; i++) begin
            check("drain.offer", int'(o_dv[0]), 1);
            check("drain.bank", o_db[0], i);
            dready[0] = 1; tick();
            dready[0] = 0;
            check("drain.dv_drop", int'(o_dv[0]), 0);
            check("drain.bank_hold", o_db[0], i);
            ddone[0] = 1; tick();
            ddone[0] = 0;
        end
        check("drain.free_back", o_free[0], 3);
        check("drain.wrap", o_db[0], 0);
        check("drain.empty_dv", int'(o_dv[0]), 0);

        // Two-bank streaming with simultaneous completions.
        freq[1] = 1; tick();
        freq[1] = 0; fdone[1] = 1; tick();
        fdone[1] = 0;
        freq[1] = 1; dready[1] = 1; tick();
        check("n2.gnt1", o_fb[1], 1);
        check("n2.dv_acc", int'(o_dv[1]), 0);
        freq[1] = 0; dready[1] = 0; fdone[1] = 1; ddone[1] = 1; tick();
        fdone[1] = 0; ddone[1] = 0;
        check("n2.both.full", o_full[1], 1);
        check("n2.both.free", o_free[1], 1);
        check("n2.both.db", o_db[1], 1);
        freq[1] = 1; tick();
        check("n2.regrant", o_fb[1], 0);
        freq[1] = 0; fdone[1] = 1; tick();
        fdone[1] = 0;
        check("n2.allfull", o_free[1], 0);
        dready[1] = 1; tick();
        dready[1] = 0;
        // Freed bank is FREE one cycle later, granted the cycle after that.
        freq[1] = 1; ddone[1] = 1; tick();
        ddone[1] = 0;
        check("n2.freed.nogrant", int'(o_gnt[1]), 0);
        check("n2.freed.free", o_free[1], 1);
        tick();
        check("n2.freed.grant", int'(o_gnt[1]), 1);
        check("n2.freed.bank", o_fb[1], 1);
        freq[1] = 0; fdone[1] = 1; dready[1] = 1; tick();
        fdone[1] = 0; dready[1] = 0;
        check("n2.mix.full", o_full[1], 1);
        ddone[1] = 1; tick();
        ddone[1] = 0; dready[1] = 1; tick();
        dready[1] = 0; ddone[1] = 1; tick();
        ddone[1] = 0;
        check("n2.end.free", o_free[1], 2);

        // Stray drain_done: sticky error, states untouched.
        ddone[0] = 1; tick();
        ddone[0] = 0;
        check("proto.set", int'(o_pe[0]), 1);
        check("proto.free", o_free[0], 3);

        // Flush with a fill outstanding and a FULL bank on offer.
        freq[0] = 1; tick();
        freq[0] = 0; fdone[0] = 1; tick();
        fdone[0] = 0; freq[0] = 1; tick();
        freq[0] = 0;
        check("pre_flush.dv", int'(o_dv[0]), 1);
        check("pre_flush.fb", o_fb[0], 1);
        fl[0] = 1; tick();
        fl[0] = 0;
        check("flush.free", o_free[0], 3);
        check("flush.dv", int'(o_dv[0]), 0);
        check("flush.fb", o_fb[0], 0);
        check("flush.db", o_db[0], 0);
        check("flush.proto_kept", int'(o_pe[0]), 1);
        freq[0] = 1; tick();
        freq[0] = 0;
        check("post_flush.bank", o_fb[0], 0);

        // Async reset in the middle of a drain.
        fdone[0] = 1; tick();
        fdone[0] = 0; dready[0] = 1; tick();
        dready[0] = 0;
        check("mid_drain.full", o_full[0], 0);
        #2 rst = 1'b0;
        #1;
        check("async.free", o_free[0], 3);
        check("async.dv", int'(o_dv[0]), 0);
        check("async.proto", int'(o_pe[0]), 0);
        check("async.db", o_db[0], 0);
        @(negedge clk) rst = 1'b1;
        tick();
        check("after_rst.free", o_free[0], 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
